id_ex_pipeline_reg: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS core. It sits between decode and execute, and is the consumer of the load-use stall request. Each cycle it either captures decoded control and operands, inserts a bubble (NOP), flushes, or holds. It drives back the `ID_EX_Rt` and `ID_EX_MemRead` values that the hazard detection logic compares against. Saturating event counters expose bubble and flush activity for performance debug.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/sat_counter.sv | 21 ++
 rtl/id_ex_pipeline_reg.sv | 127 ++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline registers.
// The execute-stage control bundle lives here so IF/ID, ID/EX and EX/MEM
// all agree on its layout.
package mips_pkg;

    localparam int ALUOP_W = 2;

    typedef struct packed {
        logic               RegWrite;
        logic               MemtoReg;
        logic               MemRead;
        logic               MemWrite;
        logic               Branch;
        logic               RegDst;
        logic               ALUSrc;
        logic [ALUOP_W-1:0] ALUOp;
    } ex_ctrl_t;

    // All-zero control word: no register write, no memory access, no branch.
    localparam ex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline event statistics.
// Stops at all-ones and clears only on reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one event per cycle, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded controls and operands, or
// replaces them with a bubble on flush, load-use stall or invalid ID slot,
// or freezes entirely on hold. Bubble and flush events are counted.
module id_ex_pipeline_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               Hold,
    input  logic               ID_Valid,
    input  logic               ID_RegWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_Branch,
    input  logic               ID_RegDst,
    input  logic               ID_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_PC_plus4,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_SignExt,
    input  logic [4:0]         ID_Rs,
    input  logic [4:0]         ID_Rt,
    input  logic [4:0]         ID_Rd,
    output logic               ID_EX_Valid,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemtoReg,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_Branch,
    output logic               ID_EX_RegDst,
    output logic               ID_EX_ALUSrc,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [DATA_W-1:0]  ID_EX_PC_plus4,
    output logic [DATA_W-1:0]  ID_EX_ReadData1,
    output logic [DATA_W-1:0]  ID_EX_ReadData2,
    output logic [DATA_W-1:0]  ID_EX_SignExt,
    output logic [4:0]         ID_EX_Rs,
    output logic [4:0]         ID_EX_Rt,
    output logic [4:0]         ID_EX_Rd,
    output logic [CNT_W-1:0]   bubble_count,
    output logic [CNT_W-1:0]   flush_count
);

    ex_ctrl_t id_ctrl;
    ex_ctrl_t ex_ctrl;
    logic     bubble_inc;
    logic     flush_inc;

    assign id_ctrl = '{RegWrite: ID_RegWrite, MemtoReg: ID_MemtoReg,
                       MemRead:  ID_MemRead,  MemWrite: ID_MemWrite,
                       Branch:   ID_Branch,   RegDst:   ID_RegDst,
                       ALUSrc:   ID_ALUSrc,   ALUOp:    ID_ALUOp};

    // Flush always wins; a stall under hold is absorbed without counting.
    assign flush_inc  = Flush;
    assign bubble_inc = Stall && !Flush && !Hold;

    // Register core: reset, then flush, hold, stall/invalid bubble, capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl         <= CTRL_NOP;
            ID_EX_Valid     <= 1'b0;
            ID_EX_PC_plus4  <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_SignExt   <= '0;
            ID_EX_Rs        <= '0;
            ID_EX_Rt        <= '0;
            ID_EX_Rd        <= '0;
        end else if (Flush || (!Hold && (Stall || !ID_Valid))) begin
            ex_ctrl         <= CTRL_NOP;
            ID_EX_Valid     <= 1'b0;
            ID_EX_PC_plus4  <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_SignExt   <= '0;
            ID_EX_Rs        <= '0;
            ID_EX_Rt        <= '0;
            ID_EX_Rd        <= '0;
        end else if (!Hold) begin
            ex_ctrl         <= id_ctrl;
            ID_EX_Valid     <= 1'b1;
            ID_EX_PC_plus4  <= ID_PC_plus4;
            ID_EX_ReadData1 <= ID_ReadData1;
            ID_EX_ReadData2 <= ID_ReadData2;
            ID_EX_SignExt   <= ID_SignExt;
            ID_EX_Rs        <= ID_Rs;
            ID_EX_Rt        <= ID_Rt;
            ID_EX_Rd        <= ID_Rd;
        end
    end

    assign ID_EX_RegWrite = ex_ctrl.RegWrite;
    assign ID_EX_MemtoReg = ex_ctrl.MemtoReg;
    assign ID_EX_MemRead  = ex_ctrl.MemRead;
    assign ID_EX_MemWrite = ex_ctrl.MemWrite;
    assign ID_EX_Branch   = ex_ctrl.Branch;
    assign ID_EX_RegDst   = ex_ctrl.RegDst;
    assign ID_EX_ALUSrc   = ex_ctrl.ALUSrc;
    assign ID_EX_ALUOp    = ex_ctrl.ALUOp;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_count)
    );

    // Decode must never issue a load and a store in the same instruction.
    a_no_read_write: assert property (@(posedge clk) disable iff (!rst_n)
        (!Flush && !Hold && !Stall && ID_Valid) |-> !(ID_MemRead && ID_MemWrite));

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg with a scoreboard of expected
// register contents, run with 4-bit counters to reach saturation quickly.
module tb_id_ex_pipeline_reg;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [8:0]    ctrl;
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] se;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [CW-1:0] bc;
        logic [CW-1:0] fc;
    } snap_t;

    logic          clk;
    logic          rst_n;
    logic          Stall, Flush, Hold, ID_Valid;
    logic          ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite;
    logic          ID_Branch, ID_RegDst, ID_ALUSrc;
    logic [1:0]    ID_ALUOp;
    logic [DW-1:0] ID_PC_plus4, ID_ReadData1, ID_ReadData2, ID_SignExt;
    logic [4:0]    ID_Rs, ID_Rt, ID_Rd;
    logic          ID_EX_Valid;
    logic          ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite;
    logic          ID_EX_Branch, ID_EX_RegDst, ID_EX_ALUSrc;
    logic [1:0]    ID_EX_ALUOp;
    logic [DW-1:0] ID_EX_PC_plus4, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExt;
    logic [4:0]    ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
    logic [CW-1:0] bubble_count, flush_count;

    int    errors;
    int    checks;
    snap_t mdl;
    snap_t obs;
    snap_t exp_s;
    snap_t sb[$];

    id_ex_pipeline_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .Hold(Hold),
        .ID_Valid(ID_Valid), .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_Branch(ID_Branch),
        .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
        .ID_PC_plus4(ID_PC_plus4), .ID_ReadData1(ID_ReadData1),
        .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_EX_Valid(ID_EX_Valid), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_Branch(ID_EX_Branch),
        .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_PC_plus4(ID_EX_PC_plus4),
        .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
        .ID_EX_SignExt(ID_EX_SignExt), .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt),
        .ID_EX_Rd(ID_EX_Rd), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gather every DUT output into one snapshot.
    function automatic snap_t sample();
        snap_t s;
        s.ctrl  = {ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite,
                   ID_EX_Branch, ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_ALUOp};
        s.valid = ID_EX_Valid;
        s.pc    = ID_EX_PC_plus4;
        s.rd1   = ID_EX_ReadData1;
        s.rd2   = ID_EX_ReadData2;
        s.se    = ID_EX_SignExt;
        s.rs    = ID_EX_Rs;
        s.rt    = ID_EX_Rt;
        s.rd    = ID_EX_Rd;
        s.bc    = bubble_count;
        s.fc    = flush_count;
        return s;
    endfunction

    // Reference behaviour for one clock edge given the current inputs.
    function automatic snap_t model_next(snap_t cur);
        snap_t n;
        snap_t bub;
        n   = cur;
        bub = '0;
        bub.bc = cur.bc;
        bub.fc = cur.fc;
        if (Flush) begin
            n = bub;
            if (cur.fc != {CW{1'b1}}) n.fc = cur.fc + 1'b1;
        end else if (Hold) begin
            n = cur;
        end else if (Stall) begin
            n = bub;
            if (cur.bc != {CW{1'b1}}) n.bc = cur.bc + 1'b1;
        end else if (!ID_Valid) begin
            n = bub;
        end else begin
            n.ctrl  = {ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
                       ID_Branch, ID_RegDst, ID_ALUSrc, ID_ALUOp};
            n.valid = 1'b1;
            n.pc    = ID_PC_plus4;
            n.rd1   = ID_ReadData1;
            n.rd2   = ID_ReadData2;
            n.se    = ID_SignExt;
            n.rs    = ID_Rs;
            n.rt    = ID_Rt;
            n.rd    = ID_Rd;
        end
        return n;
    endfunction

    // Push the expected result for the coming edge, then advance past it.
    task automatic tick();
        mdl = model_next(mdl);
        sb.push_back(mdl);
        @(posedge clk);
        #1;
    endtask

    // Drive a legal instruction onto the ID side (never load and store together).
    task automatic applyStimulus(input logic valid, input logic [4:0] rt);
        ID_Valid     = valid;
        ID_RegWrite  = 1'($urandom_range(0, 1));
        ID_MemtoReg  = 1'($urandom_range(0, 1));
        ID_MemRead   = 1'($urandom_range(0, 1));
        ID_MemWrite  = ID_MemRead ? 1'b0 : 1'($urandom_range(0, 1));
        ID_Branch    = 1'($urandom_range(0, 1));
        ID_RegDst    = 1'($urandom_range(0, 1));
        ID_ALUSrc    = 1'($urandom_range(0, 1));
        ID_ALUOp     = 2'($urandom_range(0, 3));
        ID_PC_plus4  = $urandom;
        ID_ReadData1 = $urandom;
        ID_ReadData2 = $urandom;
        ID_SignExt   = $urandom;
        ID_Rs        = 5'($urandom_range(1, 31));
        ID_Rt        = rt;
        ID_Rd        = 5'($urandom_range(1, 31));
    endtask

    task automatic test_reset();
        Stall = 0; Flush = 0; Hold = 0;
        applyStimulus(1'b1, 5'd17);
        ID_RegWrite = 1; ID_MemRead = 1; ID_MemWrite = 0;
        rst_n = 1'b0;
        mdl   = '0;
        @(posedge clk); #1;
        obs = sample();
        checks++;
        if (obs !== snap_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_initial obs=%h exp=0", obs);
        end
        rst_n = 1'b1;
        // first edge after release captures normally
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL reset_release_capture obs=%h exp=%h", obs, exp_s);
        end
        Flush = 1; tick(); void'(sb.pop_front());
        Flush = 0; Stall = 1; tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs.bc !== 4'd1 || obs.fc !== 4'd1 || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL pre_reset_counts obs=%h exp=%h", obs, exp_s);
        end
        Stall = 0; tick(); void'(sb.pop_front());
        // asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1;
        mdl = '0;
        obs = sample();
        checks++;
        if (obs !== snap_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_async obs=%h exp=0", obs);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_normal();
        Stall = 0; Flush = 0; Hold = 0;
        applyStimulus(1'b1, 5'd8);
        ID_MemRead = 1; ID_MemWrite = 0; ID_ReadData1 = 32'hDEAD_BEEF;
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs.rt !== 5'd8 || obs.ctrl[6] !== 1'b1 || obs.rd1 !== 32'hDEAD_BEEF
            || obs.valid !== 1'b1 || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL normal_pass obs=%h exp=%h", obs, exp_s);
        end
    endtask

    task automatic test_load_use();
        logic [3:0] bc0;
        bc0 = mdl.bc;
        applyStimulus(1'b1, 5'd9);
        Stall = 1;
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs.ctrl !== 9'd0 || obs.rt !== 5'd0 || obs.valid !== 1'b0
            || obs.bc !== bc0 + 4'd1 || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL load_use_bubble obs=%h exp=%h", obs, exp_s);
        end
        Stall = 0;
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs.rt !== 5'd9 || obs.valid !== 1'b1 || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL load_use_resume obs=%h exp=%h", obs, exp_s);
        end
    endtask

    task automatic test_simultaneous();
        snap_t prev;
        applyStimulus(1'b1, 5'd4);
        Flush = 1; Stall = 1;
        prev = mdl;
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs.valid !== 1'b0 || obs.fc !== prev.fc + 4'd1 || obs.bc !== prev.bc
            || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL flush_with_stall obs=%h exp=%h", obs, exp_s);
        end
        Flush = 0; Stall = 0;
        tick(); void'(sb.pop_front());
        prev = mdl;
        applyStimulus(1'b1, 5'd12);
        Hold = 1; Stall = 1;
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs !== prev || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL hold_with_stall obs=%h exp=%h", obs, prev);
        end
        Stall = 0; Flush = 1;
        prev = mdl;
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs.valid !== 1'b0 || obs.rt !== 5'd0 || obs.fc !== prev.fc + 4'd1
            || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL flush_with_hold obs=%h exp=%h", obs, exp_s);
        end
        Flush = 0; Hold = 0;
    endtask

    task automatic test_invalid();
        snap_t prev;
        applyStimulus(1'b0, 5'd6);
        ID_RegWrite = 1; ID_Rd = 5'd3;
        prev = mdl;
        tick();
        exp_s = sb.pop_front();
        obs = sample();
        checks++;
        if (obs.ctrl[8] !== 1'b0 || obs.rd !== 5'd0 || obs.bc !== prev.bc
            || obs.fc !== prev.fc || obs !== exp_s) begin
            errors++;
            $display("[TB] FAIL invalid_capture obs=%h exp=%h", obs, exp_s);
        end
    endtask

    task automatic test_saturation();
        rst_n = 0; #1; rst_n = 1;
        mdl = '0;
        sb.delete();
        Stall = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 5'($urandom_range(0, 31)));
            tick();
            exp_s = sb.pop_front();
            obs = sample();
            checks++;
            if (obs.bc !== 4'((i + 1 > 15) ? 15 : i + 1) || obs !== exp_s) begin
                errors++;
                $display("[TB] FAIL saturation_%0d obs_bc=%0d exp_bc=%0d", i, obs.bc,
                         (i + 1 > 15) ? 15 : i + 1);
            end
        end
        Stall = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 5) == 0);
            Hold  = ($urandom_range(0, 5) == 0);
            tick();
            exp_s = sb.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp_s) begin
                errors++;
                $display("[TB] FAIL back_to_back_%0d obs=%h exp=%h", i, obs, exp_s);
            end
        end
        Stall = 0; Flush = 0; Hold = 0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        test_reset();
        test_normal();
        test_load_use();
        test_simultaneous();
        test_invalid();
        test_back_to_back();
        test_saturation();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain obs=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
